// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, control-word bit layout, ALU op
// encodings and the ID/EX slot state type.
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CTRL_WIDTH = 16;
    localparam int FUNCT_W    = 4;

    // Control-word bit indices; bits [15:9] are reserved and must be zero.
    localparam int IS_MEM_TO_REG = 0;
    localparam int REG_WR_EN     = 1;
    localparam int MEM_WE        = 2;
    localparam int MEM_RE        = 3;
    localparam int IS_BRANCH     = 4;
    localparam int ALUSRC        = 5;
    localparam int ALUOP_LSB     = 6;
    localparam int ALUOP_MSB     = 7;
    localparam int IS_JAL        = 8;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } aluop_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/id_ex_reg_hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination matches
// either source of the instruction in ID (both sources compared, x0 exempt).
module hazard_detect
    import cpu_pkg::*;
(
    input  logic                  id_valid,
    input  logic                  ex_valid,
    input  logic                  ex_mem_re,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    output logic                  hazard
);

    logic rd_match;

    assign rd_match = (ex_rd == id_rs1) || (ex_rd == id_rs2);
    assign hazard   = id_valid && ex_valid && ex_mem_re
                      && (ex_rd != '0) && rd_match;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use bubble insertion and flush.
// Optional bubble counter output enabled by defining IDEX_PERF_CNT_EN.
//
// state      | meaning
// SLOT_EMPTY | EX slot holds a bubble; o_ex_ctrl is all-zero
// SLOT_FULL  | EX slot holds a real instruction
module id_ex_reg #(
    parameter int CTRL_WIDTH = cpu_pkg::CTRL_WIDTH,
    parameter int XLEN       = cpu_pkg::XLEN
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_id_valid,
    output logic                          o_id_ready,
    input  logic [CTRL_WIDTH-1:0]         i_id_ctrl,
    input  logic [XLEN-1:0]               i_id_pc,
    input  logic [XLEN-1:0]               i_id_rs1_data,
    input  logic [XLEN-1:0]               i_id_rs2_data,
    input  logic [XLEN-1:0]               i_id_imm,
    input  logic [cpu_pkg::REG_ADDR_W-1:0] i_id_rs1,
    input  logic [cpu_pkg::REG_ADDR_W-1:0] i_id_rs2,
    input  logic [cpu_pkg::REG_ADDR_W-1:0] i_id_rd,
    input  logic [cpu_pkg::FUNCT_W-1:0]   i_id_funct,
    input  logic                          i_ex_ready,
    input  logic                          i_flush,
    output logic                          o_ex_valid,
    output logic [CTRL_WIDTH-1:0]         o_ex_ctrl,
    output logic [XLEN-1:0]               o_ex_pc,
    output logic [XLEN-1:0]               o_ex_rs1_data,
    output logic [XLEN-1:0]               o_ex_rs2_data,
    output logic [XLEN-1:0]               o_ex_imm,
    output logic [cpu_pkg::REG_ADDR_W-1:0] o_ex_rs1,
    output logic [cpu_pkg::REG_ADDR_W-1:0] o_ex_rs2,
    output logic [cpu_pkg::REG_ADDR_W-1:0] o_ex_rd,
    output logic [cpu_pkg::FUNCT_W-1:0]   o_ex_funct,
    output logic                          o_load_use_stall
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [31:0]                   o_bubble_cnt
`endif
);

    import cpu_pkg::*;

    slot_state_e state_q, state_d;
    logic        advance;
    logic        hazard;
    logic        load_en;
    logic        clr_ctrl;
    logic        hazard_bubble;

    assign o_ex_valid = (state_q == SLOT_FULL);
    assign advance    = !o_ex_valid || i_ex_ready;

    hazard_detect u_hazard_detect (
        .id_valid  (i_id_valid),
        .ex_valid  (o_ex_valid),
        .ex_mem_re (o_ex_ctrl[MEM_RE]),
        .ex_rd     (o_ex_rd),
        .id_rs1    (i_id_rs1),
        .id_rs2    (i_id_rs2),
        .hazard    (hazard)
    );

    assign o_load_use_stall = hazard && !i_flush && !i_rst;
    assign o_id_ready       = advance && !hazard && !i_flush && !i_rst;

    always_comb begin
        state_d       = state_q;
        load_en       = 1'b0;
        clr_ctrl      = 1'b0;
        hazard_bubble = 1'b0;
        if (i_flush) begin
            state_d  = SLOT_EMPTY;
            clr_ctrl = 1'b1;
        end else if (!advance) begin
            state_d = state_q;
        end else if (hazard) begin
            state_d       = SLOT_EMPTY;
            clr_ctrl      = 1'b1;
            hazard_bubble = 1'b1;
        end else if (i_id_valid) begin
            state_d = SLOT_FULL;
            load_en = 1'b1;
        end else begin
            state_d  = SLOT_EMPTY;
            clr_ctrl = 1'b1;
        end
    end

    // Data fields hold across bubbles; only the control word is cleared.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= SLOT_EMPTY;
            o_ex_ctrl     <= '0;
            o_ex_pc       <= '0;
            o_ex_rs1_data <= '0;
            o_ex_rs2_data <= '0;
            o_ex_imm      <= '0;
            o_ex_rs1      <= '0;
            o_ex_rs2      <= '0;
            o_ex_rd       <= '0;
            o_ex_funct    <= '0;
        end else begin
            state_q <= state_d;
            if (load_en) begin
                o_ex_ctrl     <= i_id_ctrl;
                o_ex_pc       <= i_id_pc;
                o_ex_rs1_data <= i_id_rs1_data;
                o_ex_rs2_data <= i_id_rs2_data;
                o_ex_imm      <= i_id_imm;
                o_ex_rs1      <= i_id_rs1;
                o_ex_rs2      <= i_id_rs2;
                o_ex_rd       <= i_id_rd;
                o_ex_funct    <= i_id_funct;
            end else if (clr_ctrl) begin
                o_ex_ctrl <= '0;
            end
        end
    end

`ifdef IDEX_PERF_CNT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_bubble_cnt <= '0;
        end else if ((i_flush || hazard_bubble) && (o_bubble_cnt != 32'hFFFF_FFFF)) begin
            o_bubble_cnt <= o_bubble_cnt + 32'd1;
        end
    end
`endif

    a_bubble_ctrl_zero : assert property (@(posedge i_clk) disable iff (i_rst)
        !o_ex_valid |-> (o_ex_ctrl == '0));

endmodule
